// File: rtl/bus_if_pkg.sv
// Shared encodings, widths and FSM state type for the memory-stage bus
// interface: mem_op / miss_align codes, READ/WRITE levels, SPM select.
package bus_if_pkg;

  localparam int WORD_W  = 32;
  localparam int WADDR_W = 30;
  localparam int SPM_AW  = 12;

  localparam logic [2:0] SLV_SEL = 3'h1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    MEM_OP_NOP = 2'd0,
    MEM_OP_LDW = 2'd1,
    MEM_OP_STW = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    MA_NONE  = 2'd0,
    MA_LOAD  = 2'd1,
    MA_STORE = 2'd2
  } miss_align_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_STALL  = 2'd3
  } state_t;

endpackage

// File: rtl/bus_if_mem_ctrl.sv
// Memory-op decode: en_n_i/mem_op_i/addr_i -> access strobe, rw level,
// alignment fault; r_data_i -> stage result out_o.
module bus_if_mem_ctrl
  import bus_if_pkg::*;
(
  input  logic              en_n_i,
  input  logic [1:0]        mem_op_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] r_data_i,
  output logic [WORD_W-1:0] out_o,
  output logic              as_n_o,
  output logic              rw_o,
  output logic [1:0]        miss_align_o
);

  logic aligned;
  logic ld;
  logic st;

  assign aligned = (addr_i[1:0] == 2'b00);
  assign ld = !en_n_i && (mem_op_i == MEM_OP_LDW);
  assign st = !en_n_i && (mem_op_i == MEM_OP_STW);

  // Strobe decode kept apart from the result mux so that the
  // read data path back from bus_if never forms a block-level loop.
  always_comb begin
    as_n_o       = 1'b1;
    rw_o         = READ;
    miss_align_o = MA_NONE;
    unique case (1'b1)
      ld: begin
        if (aligned) as_n_o = 1'b0;
        else         miss_align_o = MA_LOAD;
      end
      st: begin
        if (aligned) begin
          as_n_o = 1'b0;
          rw_o   = WRITE;
        end else begin
          miss_align_o = MA_STORE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_o = '0;
    unique case (1'b1)
      ld:      if (aligned) out_o = r_data_i;
      st:      out_o = '0;
      default: if (!en_n_i) out_o = addr_i;
    endcase
  end

endmodule

// File: rtl/bus_if.sv
// Memory-stage bus interface: same-cycle SPM access, or a REQ/ACCESS
// handshake on the external bus with stall hold of the read data.
module bus_if
  import bus_if_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               en_,
  input  logic [1:0]         mem_op,
  input  logic [WORD_W-1:0]  addr_in,
  input  logic [WORD_W-1:0]  w_data,
  output logic [WORD_W-1:0]  out,
  output logic [1:0]         miss_align,
  output logic               busy,
  input  logic [WORD_W-1:0]  spm_r_data,
  output logic [SPM_AW-1:0]  spm_addr,
  output logic               spm_as_,
  output logic               spm_rw,
  output logic [WORD_W-1:0]  spm_w_data,
  input  logic [WORD_W-1:0]  bus_r_data,
  input  logic               bus_rdy_,
  input  logic               bus_grnt_,
  output logic               bus_req_,
  output logic [WADDR_W-1:0] bus_addr,
  output logic               bus_as_,
  output logic               bus_rw,
  output logic [WORD_W-1:0]  bus_w_data
);

  state_t             state_q, state_d;
  logic               req_n_q, req_n_d;
  logic               as_n_q, as_n_d;
  logic               rw_q, rw_d;
  logic [WADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]  wd_q, wd_d;
  logic [WORD_W-1:0]  rd_buf_q, rd_buf_d;

  logic [WORD_W-1:0]  r_int;
  logic               as_int;
  logic               rw_int;
  logic               spm_sel;

  bus_if_mem_ctrl u_mem_ctrl (
    .en_n_i       (en_),
    .mem_op_i     (mem_op),
    .addr_i       (addr_in),
    .r_data_i     (r_int),
    .out_o        (out),
    .as_n_o       (as_int),
    .rw_o         (rw_int),
    .miss_align_o (miss_align)
  );

  assign spm_sel    = (addr_in[31:29] == SLV_SEL);
  assign spm_addr   = addr_in[SPM_AW+1:2];
  assign spm_rw     = rw_int;
  assign spm_w_data = w_data;

  assign bus_req_   = req_n_q;
  assign bus_as_    = as_n_q;
  assign bus_rw     = rw_q;
  assign bus_addr   = addr_q;
  assign bus_w_data = wd_q;

  always_comb begin
    state_d  = state_q;
    req_n_d  = req_n_q;
    as_n_d   = 1'b1;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rd_buf_d = rd_buf_q;
    busy     = 1'b0;
    spm_as_  = 1'b1;
    r_int    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!as_int) begin
          if (spm_sel) begin
            if (!stall) begin
              spm_as_ = 1'b0;
              if (rw_int == READ) r_int = spm_r_data;
            end
          end else begin
            busy    = 1'b1;
            state_d = ST_REQ;
            req_n_d = 1'b0;
            addr_d  = addr_in[WORD_W-1:2];
            rw_d    = rw_int;
            if (rw_int == WRITE) wd_d = w_data;
          end
        end
      end
      ST_REQ: begin
        busy = 1'b1;
        if (!bus_grnt_) begin
          state_d = ST_ACCESS;
          as_n_d  = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (!bus_rdy_) begin
          if (rw_int == READ) begin
            r_int    = bus_r_data;
            rd_buf_d = bus_r_data;
          end
          req_n_d = 1'b1;
          addr_d  = '0;
          rw_d    = READ;
          wd_d    = '0;
          state_d = stall ? ST_STALL : ST_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      ST_STALL: begin
        if (rw_int == READ) r_int = rd_buf_q;
        if (!stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      req_n_q  <= 1'b1;
      as_n_q   <= 1'b1;
      rw_q     <= READ;
      addr_q   <= '0;
      wd_q     <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      req_n_q  <= req_n_d;
      as_n_q   <= as_n_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      rd_buf_q <= rd_buf_d;
    end
  end

endmodule

// File: tb/tb_bus_if.sv
// Directed scoreboard bench for bus_if: SPM, misalign, passthrough,
// bus read/write handshake, stall hold and async reset.
module tb_bus_if;
  import bus_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        en_;
  logic [1:0]  mem_op;
  logic [31:0] addr_in;
  logic [31:0] w_data;
  logic [31:0] out;
  logic [1:0]  miss_align;
  logic        busy;
  logic [31:0] spm_r_data;
  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_w_data;
  logic [31:0] bus_r_data;
  logic        bus_rdy_;
  logic        bus_grnt_;
  logic        bus_req_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_w_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bus_if dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .en_        (en_),
    .mem_op     (mem_op),
    .addr_in    (addr_in),
    .w_data     (w_data),
    .out        (out),
    .miss_align (miss_align),
    .busy       (busy),
    .spm_r_data (spm_r_data),
    .spm_addr   (spm_addr),
    .spm_as_    (spm_as_),
    .spm_rw     (spm_rw),
    .spm_w_data (spm_w_data),
    .bus_r_data (bus_r_data),
    .bus_rdy_   (bus_rdy_),
    .bus_grnt_  (bus_grnt_),
    .bus_req_   (bus_req_),
    .bus_addr   (bus_addr),
    .bus_as_    (bus_as_),
    .bus_rw     (bus_rw),
    .bus_w_data (bus_w_data)
  );

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: got %h want %h", tag, obs, e);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; en_ = 1'b1;
    mem_op = MEM_OP_NOP; addr_in = '0; w_data = '0;
    spm_r_data = '0; bus_r_data = '0;
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;

    // reset state
    cyc(); cyc();
    push(32'h1); push(32'h1); push(32'h0);
    push(32'h1); push(32'h0); push(32'(ST_IDLE));
    smp();
    chk("rst_req", 32'(bus_req_));
    chk("rst_as", 32'(bus_as_));
    chk("rst_addr", 32'(bus_addr));
    chk("rst_rw", 32'(bus_rw));
    chk("rst_busy", 32'(busy));
    chk("rst_state", 32'(dut.state_q));
    cyc(); rst = 1'b1;

    // SPM load, same cycle
    cyc();
    en_ = 1'b0; mem_op = MEM_OP_LDW;
    addr_in = 32'h2000_0010; spm_r_data = 32'hCAFE_0001;
    push(32'h0); push(32'h004); push(32'hCAFE_0001);
    push(32'h0); push(32'h1); push(32'h0);
    smp();
    chk("spm_ld_as", 32'(spm_as_));
    chk("spm_ld_addr", 32'(spm_addr));
    chk("spm_ld_out", out);
    chk("spm_ld_busy", 32'(busy));
    chk("spm_ld_rw", 32'(spm_rw));
    chk("spm_ld_ma", 32'(miss_align));

    // SPM load blocked by stall
    cyc(); stall = 1'b1;
    push(32'h1); push(32'h0);
    smp();
    chk("spm_stall_as", 32'(spm_as_));
    chk("spm_stall_out", out);

    // SPM store
    cyc(); stall = 1'b0;
    mem_op = MEM_OP_STW; addr_in = 32'h2000_0020; w_data = 32'h0000_55AA;
    push(32'h0); push(32'h0); push(32'h0000_55AA); push(32'h0); push(32'h008);
    smp();
    chk("spm_st_as", 32'(spm_as_));
    chk("spm_st_rw", 32'(spm_rw));
    chk("spm_st_wd", spm_w_data);
    chk("spm_st_out", out);
    chk("spm_st_addr", 32'(spm_addr));

    // misaligned store
    cyc(); addr_in = 32'h2000_0012;
    push(32'h2); push(32'h1); push(32'h1); push(32'h0);
    smp();
    chk("mis_st_ma", 32'(miss_align));
    chk("mis_st_spm", 32'(spm_as_));
    chk("mis_st_req", 32'(bus_req_));
    chk("mis_st_busy", 32'(busy));

    // misaligned load on a bus address: no request
    cyc(); mem_op = MEM_OP_LDW; addr_in = 32'h0000_0101;
    push(32'h1); push(32'h0); push(32'h0);
    smp();
    chk("mis_ld_ma", 32'(miss_align));
    chk("mis_ld_out", out);
    chk("mis_ld_busy", 32'(busy));
    cyc();
    push(32'h1); push(32'(ST_IDLE));
    smp();
    chk("mis_ld_req", 32'(bus_req_));
    chk("mis_ld_state", 32'(dut.state_q));

    // NOP passthrough, then disabled stage
    cyc(); mem_op = MEM_OP_NOP; addr_in = 32'h1234_5678;
    push(32'h1234_5678); push(32'h0);
    smp();
    chk("nop_out", out);
    chk("nop_ma", 32'(miss_align));
    cyc(); en_ = 1'b1; mem_op = MEM_OP_LDW; addr_in = 32'h2000_0010;
    push(32'h0); push(32'h1);
    smp();
    chk("dis_out", out);
    chk("dis_spm", 32'(spm_as_));

    // bus read: grant after 2 REQ cycles, ready after 3 ACCESS cycles
    cyc(); en_ = 1'b0; mem_op = MEM_OP_LDW; addr_in = 32'h0000_0100;
    push(32'h1); push(32'h1); push(32'(ST_IDLE));
    smp();
    chk("rd_idle_busy", 32'(busy));
    chk("rd_idle_req", 32'(bus_req_));
    chk("rd_idle_state", 32'(dut.state_q));
    cyc();
    push(32'h0); push(32'h40); push(32'h1); push(32'h1); push(32'h1);
    smp();
    chk("rd_req_req", 32'(bus_req_));
    chk("rd_req_addr", 32'(bus_addr));
    chk("rd_req_rw", 32'(bus_rw));
    chk("rd_req_as", 32'(bus_as_));
    chk("rd_req_busy", 32'(busy));
    cyc(); bus_grnt_ = 1'b0;
    push(32'(ST_REQ)); push(32'h1);
    smp();
    chk("rd_req2_state", 32'(dut.state_q));
    chk("rd_req2_busy", 32'(busy));
    cyc(); bus_grnt_ = 1'b1;
    push(32'(ST_ACCESS)); push(32'h0); push(32'h1); push(32'h0);
    smp();
    chk("rd_acc_state", 32'(dut.state_q));
    chk("rd_acc_as", 32'(bus_as_));
    chk("rd_acc_busy", 32'(busy));
    chk("rd_acc_out", out);
    cyc();
    push(32'h1); push(32'h1);
    smp();
    chk("rd_acc2_as", 32'(bus_as_));
    chk("rd_acc2_busy", 32'(busy));
    cyc(); bus_rdy_ = 1'b0; bus_r_data = 32'hDEAD_BEEF;
    push(32'h0); push(32'hDEAD_BEEF);
    smp();
    chk("rd_rdy_busy", 32'(busy));
    chk("rd_rdy_out", out);
    cyc(); bus_rdy_ = 1'b1; bus_r_data = '0; en_ = 1'b1;
    push(32'(ST_IDLE)); push(32'h1); push(32'h0); push(32'h1);
    smp();
    chk("rd_done_state", 32'(dut.state_q));
    chk("rd_done_req", 32'(bus_req_));
    chk("rd_done_addr", 32'(bus_addr));
    chk("rd_done_rw", 32'(bus_rw));

    // bus write
    cyc(); en_ = 1'b0; mem_op = MEM_OP_STW;
    addr_in = 32'h0000_0300; w_data = 32'hA5A5_A5A5; bus_grnt_ = 1'b0;
    cyc();
    push(32'h0); push(32'hC0); push(32'hA5A5_A5A5); push(32'h0);
    smp();
    chk("wr_req_rw", 32'(bus_rw));
    chk("wr_req_addr", 32'(bus_addr));
    chk("wr_req_wd", bus_w_data);
    chk("wr_req_req", 32'(bus_req_));
    cyc(); bus_grnt_ = 1'b1; bus_rdy_ = 1'b0;
    push(32'h0); push(32'h0);
    smp();
    chk("wr_rdy_busy", 32'(busy));
    chk("wr_rdy_out", out);
    cyc(); bus_rdy_ = 1'b1; en_ = 1'b1;
    push(32'h0); push(32'h1);
    smp();
    chk("wr_done_wd", bus_w_data);
    chk("wr_done_rw", 32'(bus_rw));

    // stall hold after a bus read
    cyc(); en_ = 1'b0; mem_op = MEM_OP_LDW;
    addr_in = 32'h0000_0180; bus_grnt_ = 1'b0;
    cyc();
    push(32'(ST_REQ));
    smp();
    chk("st_req_state", 32'(dut.state_q));
    cyc(); bus_grnt_ = 1'b1; bus_rdy_ = 1'b0;
    bus_r_data = 32'h0BAD_F00D; stall = 1'b1;
    push(32'h0); push(32'h0BAD_F00D);
    smp();
    chk("st_rdy_busy", 32'(busy));
    chk("st_rdy_out", out);
    cyc(); bus_rdy_ = 1'b1; bus_r_data = 32'h1111_1111;
    for (int i = 0; i < 2; i++) begin
      push(32'(ST_STALL)); push(32'h0BAD_F00D); push(32'h0); push(32'h1);
      smp();
      chk("st_hold_state", 32'(dut.state_q));
      chk("st_hold_out", out);
      chk("st_hold_busy", 32'(busy));
      chk("st_hold_req", 32'(bus_req_));
      cyc();
    end
    stall = 1'b0;
    push(32'h0BAD_F00D);
    smp();
    chk("st_last_out", out);
    cyc(); en_ = 1'b1;
    push(32'(ST_IDLE)); push(32'h0);
    smp();
    chk("st_exit_state", 32'(dut.state_q));
    chk("st_exit_out", out);

    // async reset in the middle of REQ
    cyc(); en_ = 1'b0; mem_op = MEM_OP_LDW; addr_in = 32'h0000_0200;
    cyc();
    push(32'h0); push(32'(ST_REQ));
    smp();
    chk("ar_req_req", 32'(bus_req_));
    chk("ar_req_state", 32'(dut.state_q));
    #2 rst = 1'b0;
    #1;
    push(32'h1); push(32'(ST_IDLE)); push(32'h0);
    chk("ar_req", 32'(bus_req_));
    chk("ar_state", 32'(dut.state_q));
    chk("ar_addr", 32'(bus_addr));
    en_ = 1'b1;
    cyc(); rst = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
